// File: rtl/shift_in_param.sv
// Serial-to-parallel capture of WIDTH bits (MSB- or LSB-first) with synchronous
// start-edge detect, bit-enable qualification and a done flag held until ack.
module shift_in_param #(
  parameter int WIDTH     = 12,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x_in,
  input  logic             x_en,
  input  logic             sx,
  input  logic             ack,
  output logic [WIDTH-1:0] x_parallel,
  output logic             fx,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             sx_d;
  logic             start;

  // Insert one serial bit at the end selected by MSB_FIRST.
  function automatic logic [WIDTH-1:0] shift_bit(input logic [WIDTH-1:0] word,
                                                 input logic             bit_in);
    if (MSB_FIRST) return {word[WIDTH-2:0], bit_in};
    else           return {bit_in, word[WIDTH-1:1]};
  endfunction

  assign start = sx & ~sx_d;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    word_nxt  = x_parallel;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          count_nxt = '0;
          word_nxt  = '0;
        end
      end
      SHIFT: begin
        // A fresh start aborts the word in flight; the bit on that edge is dropped.
        if (start) begin
          count_nxt = '0;
          word_nxt  = '0;
        end else if (x_en) begin
          word_nxt  = shift_bit(x_parallel, x_in);
          count_nxt = count + CNT_W'(1);
          if (count == LAST_BIT) state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = SHIFT;
          count_nxt = '0;
          word_nxt  = '0;
        end else if (ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        word_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      x_parallel <= '0;
      sx_d       <= 1'b0;
      fx         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      x_parallel <= word_nxt;
      sx_d       <= sx;
      fx         <= (state_nxt == DONE);
      busy       <= (state_nxt == SHIFT);
    end
  end

endmodule
